// File: rtl/matrix_stream_pkg.sv
// matrix_stream_pkg
// Shared definitions for the matrix result streamer: FSM state encoding,
// default datapath widths and the largest legal matrix dimension.
package matrix_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int DIM_W   = 5;
    localparam int MAX_DIM = 16;

endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo
// Two-entry FIFO used as the output buffer of the result streamer.
// A push and a pop in the same cycle are both honoured, also when full.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_push, i_din  write strobe and data
//   i_pop          read strobe (ignored while empty)
//   o_dout         head entry, held stable until popped
//   o_full/o_empty occupancy flags, o_count occupancy (0..2)
module stream_skid_fifo #(
    parameter int width = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [width-1:0] i_din,
    input  logic             i_pop,
    output logic [width-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [1:0]       o_count
);
    logic [width-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // qualify strobes: a pop frees a slot for a same-cycle push
    always_comb begin
        w_do_pop  = i_pop && (r_count != 2'd0);
        w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);
    end

    // storage, pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
// Reads a result matrix out of the shared single-port RAM after the
// multiplier finishes and emits it on a valid/ready stream with row and
// matrix end markers. One element per clock is sustained while the
// consumer keeps i_out_ready high.
// Optional feature: define MATRIX_STREAMER_TRANSPOSE_EN to add i_transpose,
// which selects column-major emission (o_out_row_last then marks column ends).
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_start                           one-cycle pulse starting a transfer
//   i_base_addr, i_n_rows, i_n_cols   matrix placement and shape
//   o_ram_addr, i_ram_r_data          RAM read port (data 1 cycle after addr)
//   o_out_data, o_out_valid, i_out_ready, o_out_row_last, o_out_last  stream
//   o_busy                            transfer active, block owns the RAM port
//   o_done                            pulse after the final beat is accepted
//   o_err                             pulse when a request is rejected
module matrix_result_streamer
    import matrix_stream_pkg::*;
#(
    parameter int data_w = DATA_W,
    parameter int addr_w = ADDR_W,
    parameter int dim_w  = DIM_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
`ifdef MATRIX_STREAMER_TRANSPOSE_EN
    input  logic              i_transpose,
`endif
    input  logic [addr_w-1:0] i_base_addr,
    input  logic [dim_w-1:0]  i_n_rows,
    input  logic [dim_w-1:0]  i_n_cols,
    output logic [addr_w-1:0] o_ram_addr,
    input  logic [data_w-1:0] i_ram_r_data,
    output logic [data_w-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_row_last,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
    localparam int CHK_W  = addr_w + 1;
    localparam int FIFO_W = data_w + 2;
    localparam logic [CHK_W-1:0] ADDR_LIMIT = {1'b1, {addr_w{1'b0}}};

    state_t             r_state;
    state_t             w_state_next;
    logic [addr_w-1:0]  r_base;
    logic [addr_w-1:0]  r_ptr;
    logic [dim_w-1:0]   r_rows;
    logic [dim_w-1:0]   r_cols;
    logic [dim_w-1:0]   r_inner;
    logic [dim_w-1:0]   r_outer;
    logic               r_rd_vld;
    logic               r_rd_row_last;
    logic               r_rd_last;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
`ifdef MATRIX_STREAMER_TRANSPOSE_EN
    logic               r_transpose;
    logic [addr_w-1:0]  r_col_start;
`endif

    logic [CHK_W-1:0]   w_end;
    logic               w_check_ok;
    logic [dim_w-1:0]   w_inner_max;
    logic [dim_w-1:0]   w_outer_max;
    logic               w_inner_last;
    logic               w_elem_last;
    logic [addr_w-1:0]  w_ptr_next;
    logic               w_pop;
    logic               w_credit_ok;
    logic               w_issue;
    logic               w_final_pop;
    logic [FIFO_W-1:0]  w_head;
    logic               w_full;
    logic               w_empty;
    logic [1:0]         w_occ;

    // request validation; ranges are checked first so the product cannot overflow
    always_comb begin
        w_end      = CHK_W'(r_base) + (CHK_W'(r_rows) * CHK_W'(r_cols));
        w_check_ok = (r_rows != '0) && (r_cols != '0) &&
                     (int'(r_rows) <= MAX_DIM) && (int'(r_cols) <= MAX_DIM) &&
                     (w_end <= ADDR_LIMIT);
    end

    // inner counter walks along the emitted row (or column), outer across them
    always_comb begin
`ifdef MATRIX_STREAMER_TRANSPOSE_EN
        if (r_transpose) begin
            w_inner_max = r_rows - dim_w'(1);
            w_outer_max = r_cols - dim_w'(1);
        end else begin
            w_inner_max = r_cols - dim_w'(1);
            w_outer_max = r_rows - dim_w'(1);
        end
`else
        w_inner_max = r_cols - dim_w'(1);
        w_outer_max = r_rows - dim_w'(1);
`endif
        w_inner_last = (r_inner == w_inner_max);
        w_elem_last  = w_inner_last && (r_outer == w_outer_max);
    end

    // next read address
    always_comb begin
`ifdef MATRIX_STREAMER_TRANSPOSE_EN
        if (r_transpose && w_inner_last) begin
            w_ptr_next = r_col_start + addr_w'(1);
        end else if (r_transpose) begin
            w_ptr_next = r_ptr + addr_w'(r_cols);
        end else begin
            w_ptr_next = r_ptr + addr_w'(1);
        end
`else
        w_ptr_next = r_ptr + addr_w'(1);
`endif
    end

    // read credit: the in-flight read plus the FIFO entries left after this
    // cycle's pop must stay below the FIFO depth, so a read issued now always
    // finds room even if the consumer stalls from the next cycle on
    always_comb begin
        w_pop       = !w_empty && i_out_ready;
        w_credit_ok = ({2'b00, r_rd_vld} + {1'b0, w_occ}) < (3'd2 + {2'b00, w_pop});
        w_issue     = (r_state == ST_STREAM) && w_credit_ok && !(w_full && !w_pop);
        w_final_pop = (r_state == ST_DRAIN) && w_pop && w_head[0];
    end

    // next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_CHECK;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (w_check_ok) begin
                    w_state_next = ST_STREAM;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (w_issue && w_elem_last) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (w_final_pop) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // state, request latch, address walk and read pipeline
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_base        <= '0;
            r_rows        <= '0;
            r_cols        <= '0;
            r_ptr         <= '0;
            r_inner       <= '0;
            r_outer       <= '0;
            r_rd_vld      <= 1'b0;
            r_rd_row_last <= 1'b0;
            r_rd_last     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
`ifdef MATRIX_STREAMER_TRANSPOSE_EN
            r_transpose   <= 1'b0;
            r_col_start   <= '0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_err         <= (r_state == ST_CHECK) && !w_check_ok;
            r_done        <= w_final_pop;
            r_rd_vld      <= w_issue;
            r_rd_row_last <= w_inner_last;
            r_rd_last     <= w_elem_last;
            if ((r_state == ST_IDLE) && i_start) begin
                r_base      <= i_base_addr;
                r_rows      <= i_n_rows;
                r_cols      <= i_n_cols;
`ifdef MATRIX_STREAMER_TRANSPOSE_EN
                r_transpose <= i_transpose;
`endif
            end
            if ((r_state == ST_CHECK) && w_check_ok) begin
                r_busy      <= 1'b1;
                r_ptr       <= r_base;
                r_inner     <= '0;
                r_outer     <= '0;
`ifdef MATRIX_STREAMER_TRANSPOSE_EN
                r_col_start <= r_base;
`endif
            end else if (w_final_pop) begin
                r_busy <= 1'b0;
            end
            // the pointer is not advanced past the final element, so it never wraps
            if (w_issue && !w_elem_last) begin
                r_ptr <= w_ptr_next;
                if (w_inner_last) begin
                    r_inner <= '0;
                    r_outer <= r_outer + dim_w'(1);
`ifdef MATRIX_STREAMER_TRANSPOSE_EN
                    r_col_start <= r_col_start + addr_w'(1);
`endif
                end else begin
                    r_inner <= r_inner + dim_w'(1);
                end
            end
        end
    end

    stream_skid_fifo #(
        .width (FIFO_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_rd_vld),
        .i_din   ({i_ram_r_data, r_rd_row_last, r_rd_last}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

    assign o_ram_addr     = r_ptr;
    assign o_out_data     = w_head[FIFO_W-1:2];
    assign o_out_row_last = w_head[1];
    assign o_out_last     = w_head[0];
    assign o_out_valid    = !w_empty;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;

endmodule

// File: tb/tb_matrix_result_streamer.sv
module tb_matrix_result_streamer;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int NW = 5;

    typedef struct {
        logic [DW-1:0] d;
        logic          rl;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [NW-1:0] n_rows;
    logic [NW-1:0] n_cols;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_r_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_row_last;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;
`ifdef MATRIX_STREAMER_TRANSPOSE_EN
    logic          transpose;
`endif

    logic [DW-1:0] mem [512];
    beat_t         exp_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    // RAM model: data valid one cycle after the address is presented
    always @(posedge clk) ram_r_data <= mem[ram_addr];

    matrix_result_streamer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
`ifdef MATRIX_STREAMER_TRANSPOSE_EN
        .i_transpose    (transpose),
`endif
        .i_base_addr    (base_addr),
        .i_n_rows       (n_rows),
        .i_n_cols       (n_cols),
        .o_ram_addr     (ram_addr),
        .i_ram_r_data   (ram_r_data),
        .o_out_data     (out_data),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_row_last (out_row_last),
        .o_out_last     (out_last),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // one transfer: mode 0 ready=1, 1 ready toggles, 2 ready random;
    // abort_after>0 resets after that many beats; spurious adds ignored starts
    task automatic xfer(input int base, input int rows, input int cols, input bit tr,
                        input int mode, input int abort_after, input bit spurious);
        beat_t         b;
        int            cyc;
        int            got;
        int            first_v;
        bit            legal;
        bit            fin;
        bit            aborted;
        bit            prev_hold;
        logic [DW-1:0] prev_d;
        logic          prev_rl;
        logic          prev_l;

        exp_q.delete();
        legal = (rows >= 1) && (rows <= 16) && (cols >= 1) && (cols <= 16) &&
                (base + rows * cols <= 512);
        if (legal) begin
            if (tr) begin
                for (int c = 0; c < cols; c++)
                    for (int r = 0; r < rows; r++) begin
                        b.d  = mem[base + r * cols + c];
                        b.rl = (r == rows - 1);
                        b.l  = (r == rows - 1) && (c == cols - 1);
                        exp_q.push_back(b);
                    end
            end else begin
                for (int r = 0; r < rows; r++)
                    for (int c = 0; c < cols; c++) begin
                        b.d  = mem[base + r * cols + c];
                        b.rl = (c == cols - 1);
                        b.l  = (r == rows - 1) && (c == cols - 1);
                        exp_q.push_back(b);
                    end
            end
        end

        @(negedge clk);
        start     = 1'b1;
        base_addr = AW'(base);
        n_rows    = NW'(rows);
        n_cols    = NW'(cols);
`ifdef MATRIX_STREAMER_TRANSPOSE_EN
        transpose = tr;
`endif
        @(posedge clk); #1;
        if (!spurious) start = 1'b0;

        if (!legal) begin
            @(posedge clk); #1;
            check("err_pulse", err, 1'b1);
            check("err_busy", busy, 1'b0);
            check("err_valid", out_valid, 1'b0);
            @(posedge clk); #1;
            check("err_one_cycle", err, 1'b0);
            check("err_busy2", busy, 1'b0);
            check("err_valid2", out_valid, 1'b0);
            return;
        end

        cyc = 0; got = 0; first_v = -1; fin = 0; aborted = 0; prev_hold = 0;
        prev_d = '0; prev_rl = 1'b0; prev_l = 1'b0;
        while (!fin && !aborted && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (spurious && cyc == 1) start = 1'b0;
            if (spurious && cyc == 5) begin
                start     = 1'b1;
                base_addr = AW'($urandom_range(0, 511));
                n_rows    = NW'($urandom_range(1, 16));
                n_cols    = NW'($urandom_range(1, 16));
            end
            if (spurious && cyc == 6) start = 1'b0;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (cyc == 1) check("busy_set", busy, 1'b1);
            if (out_valid && first_v < 0) begin
                first_v = cyc;
                check("first_valid_latency", first_v, 3);
            end
            if (prev_hold) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_d);
                check("hold_row_last", out_row_last, prev_rl);
                check("hold_last", out_last, prev_l);
            end
            if (mode == 0 && got > 0) check("no_bubble", out_valid, 1'b1);
            check("done_early", done, 1'b0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", out_valid, 1'b0);
                    fin = 1;
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", out_data, b.d);
                    check("beat_row_last", out_row_last, b.rl);
                    check("beat_last", out_last, b.l);
                    got++;
                    if (exp_q.size() == 0) fin = 1;
                    if (abort_after > 0 && got == abort_after) aborted = 1;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_d    = out_data;
            prev_rl   = out_row_last;
            prev_l    = out_last;
        end

        if (aborted) begin
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            check("rst_valid", out_valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            rst = 1'b0;
            exp_q.delete();
            repeat (6) begin
                @(posedge clk); #1;
                check("post_rst_done", done, 1'b0);
                check("post_rst_valid", out_valid, 1'b0);
            end
            return;
        end

        check("beats_remaining", exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int rows;
        int cols;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        n_rows    = '0;
        n_cols    = '0;
        out_ready = 1'b0;
`ifdef MATRIX_STREAMER_TRANSPOSE_EN
        transpose = 1'b0;
`endif
        for (int i = 0; i < 512; i++) mem[i] = $urandom;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_addr", ram_addr, '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_row_last", out_row_last, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_busy0", busy, 1'b0);
        check("rst_done0", done, 1'b0);
        check("rst_err0", err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) mem[32'h040 + i] = 32'(i + 1);
        xfer(32'h040, 2, 2, 1'b0, 0, 0, 1'b0);
        xfer(32'h100, 4, 4, 1'b0, 1, 0, 1'b0);
        xfer(32'h000, 0, 3, 1'b0, 0, 0, 1'b0);
        xfer(32'h000, 17, 1, 1'b0, 0, 0, 1'b0);
        xfer(32'h1F0, 4, 5, 1'b0, 0, 0, 1'b0);
        xfer(32'h1F0, 4, 4, 1'b0, 0, 0, 1'b0);
        xfer(32'h010, 3, 3, 1'b0, 0, 4, 1'b0);
        xfer(32'h000, 1, 1, 1'b0, 0, 0, 1'b0);
        xfer(32'h1FF, 1, 1, 1'b0, 2, 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            rows = $urandom_range(1, 16);
            cols = $urandom_range(1, 16);
            xfer($urandom_range(0, 512 - rows * cols), rows, cols, 1'b0, 2, 0,
                 (rows * cols >= 6));
        end

`ifdef MATRIX_STREAMER_TRANSPOSE_EN
        for (int i = 0; i < 6; i++) mem[32'h080 + i] = 32'(i + 1);
        xfer(32'h080, 2, 3, 1'b1, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            rows = $urandom_range(1, 16);
            cols = $urandom_range(1, 16);
            xfer($urandom_range(0, 512 - rows * cols), rows, cols, 1'b1, 2, 0, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
